oq_fifo_arbiter: RTL and testbench

- Memory-clock-side arbiter for the SRAM output-queue datapath.
- Accepts 202-bit packed packet words from the AXI-stream-to-FIFO packer, together with a 5-bit output-queue bitmap.
- Buffers one whole packet, then replays it once for each selected output queue, tagging every word with its queue index for the memory writer.
- Throttles the upstream packer with a next-packet enable.

---
 rtl/oq_fifo_arbiter.sv | 154 +++++++++++++++
 tb/tb_oq_fifo_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/oq_fifo_arbiter.sv
// Output-queue arbiter: buffers one packet, then replays it once per selected
// output queue (lowest index first), tagging each word with its queue index.
//
// state     | meaning
// S_IDLE    | waiting for a header word; upstream may start a packet
// S_CAPTURE | storing packet words until the incoming last word
// S_EMIT    | replaying the buffer once per set mask bit
module oq_fifo_arbiter #(
    parameter int DATA_WIDTH = 202,
    parameter int OQ_NUM     = 5,
    parameter int QID_WIDTH  = 3,
    parameter int DEPTH      = 128
) (
    input  logic                  memclk,
    input  logic                  reset,
    input  logic [OQ_NUM-1:0]     oq,
    input  logic                  din_valid,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  next_pkg_en,
    output logic [QID_WIDTH-1:0]  queue_id,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   DEPTH_C   = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CAPTURE = 2'd1;
    localparam logic [1:0] S_EMIT    = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [OQ_NUM-1:0]     mask_q, mask_d;
    logic [AW:0]           wr_cnt_q, wr_cnt_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  dout_valid_q, dout_valid_d;
    logic [QID_WIDTH-1:0]  queue_id_q, queue_id_d;
    logic                  next_pkg_en_q, next_pkg_en_d;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic                  we;
    logic [AW-1:0]         waddr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [QID_WIDTH-1:0]  cur;

    always_comb begin
        cur = '0;
        for (int i = OQ_NUM - 1; i >= 0; i--) begin
            if (mask_q[i]) cur = QID_WIDTH'(i);
        end
    end

    always_comb begin
        state_d      = state_q;
        mask_d       = mask_q;
        wr_cnt_d     = wr_cnt_q;
        rd_ptr_d     = rd_ptr_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        queue_id_d   = queue_id_q;
        we           = 1'b0;
        waddr        = wr_cnt_q[AW-1:0];

        case (state_q)
            S_IDLE: begin
                if (din_valid && din[4:2] == 3'd0) begin
                    we       = 1'b1;
                    waddr    = '0;
                    mask_d   = oq;
                    rd_ptr_d = '0;
                    if (din[1]) begin
                        state_d  = (oq != '0) ? S_EMIT : S_IDLE;
                        wr_cnt_d = (oq != '0) ? (AW+1)'(1) : '0;
                    end else begin
                        state_d  = S_CAPTURE;
                        wr_cnt_d = (AW+1)'(1);
                    end
                end
            end
            S_CAPTURE: begin
                if (din_valid) begin
                    // Words beyond capacity are dropped but still watched for last
                    if (wr_cnt_q < DEPTH_C) begin
                        we       = 1'b1;
                        wr_cnt_d = wr_cnt_q + (AW+1)'(1);
                    end
                    if (din[1]) begin
                        if (mask_q != '0) begin
                            state_d = S_EMIT;
                        end else begin
                            state_d  = S_IDLE;
                            wr_cnt_d = '0;
                        end
                    end
                end
            end
            S_EMIT: begin
                dout_d       = mem_q[rd_ptr_q];
                dout_valid_d = 1'b1;
                queue_id_d   = cur;
                if ({1'b0, rd_ptr_q} + (AW+1)'(1) == wr_cnt_q) begin
                    rd_ptr_d = '0;
                    mask_d   = mask_q & ~(OQ_NUM'(1) << cur);
                    if (mask_d == '0) begin
                        state_d  = S_IDLE;
                        wr_cnt_d = '0;
                    end
                end else begin
                    rd_ptr_d = rd_ptr_q + AW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        wdata = din;
        if (waddr == LAST_ADDR) wdata[1] = 1'b1;

        next_pkg_en_d = (state_d == S_IDLE);
    end

    always_ff @(posedge memclk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    always_ff @(posedge memclk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            mask_q        <= '0;
            wr_cnt_q      <= '0;
            rd_ptr_q      <= '0;
            dout_q        <= '0;
            dout_valid_q  <= 1'b0;
            queue_id_q    <= '0;
            next_pkg_en_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            mask_q        <= mask_d;
            wr_cnt_q      <= wr_cnt_d;
            rd_ptr_q      <= rd_ptr_d;
            dout_q        <= dout_d;
            dout_valid_q  <= dout_valid_d;
            queue_id_q    <= queue_id_d;
            next_pkg_en_q <= next_pkg_en_d;
        end
    end

    assign dout        = dout_q;
    assign dout_valid  = dout_valid_q;
    assign queue_id    = queue_id_q;
    assign next_pkg_en = next_pkg_en_q;

endmodule

// File: tb/tb_oq_fifo_arbiter.sv
// Bench for oq_fifo_arbiter: directed packets, expected replays queued per
// packet and checked by an independent output monitor.
module tb_oq_fifo_arbiter;

    localparam int DW       = 202;
    localparam int ON       = 5;
    localparam int QW       = 3;
    localparam int TB_DEPTH = 8;

    logic          memclk = 1'b0;
    logic          reset = 1'b0;
    logic [ON-1:0] oq = '0;
    logic          din_valid = 1'b0;
    logic [DW-1:0] din = '0;
    logic          next_pkg_en;
    logic [QW-1:0] queue_id;
    logic [DW-1:0] dout;
    logic          dout_valid;

    oq_fifo_arbiter #(
        .DATA_WIDTH(DW), .OQ_NUM(ON), .QID_WIDTH(QW), .DEPTH(TB_DEPTH)
    ) dut (
        .memclk(memclk), .reset(reset), .oq(oq), .din_valid(din_valid), .din(din),
        .next_pkg_en(next_pkg_en), .queue_id(queue_id), .dout(dout), .dout_valid(dout_valid)
    );

    always #5 memclk = ~memclk;

    typedef struct {
        logic [QW-1:0] qid;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   ncyc = 0;
    int   out_cnt = 0;
    int   out_ncyc[$];
    int   last_ncyc = 0;
    int   mark = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per valid output word
    initial begin
        exp_t e;
        forever begin
            @(negedge memclk);
            ncyc++;
            if (!reset && dout_valid) begin
                out_cnt++;
                out_ncyc.push_back(ncyc);
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_output: got qid %0d data %h, required no output", queue_id, dout);
                end else begin
                    e = sb.pop_front();
                    if (queue_id !== e.qid || dout !== e.data) begin
                        miscompares++;
                        $display("FAIL replay_word: got qid %0d data %h, required qid %0d data %h",
                                 queue_id, dout, e.qid, e.data);
                    end
                end
            end
        end
    end

    function automatic logic [DW-1:0] mk(input int base, input int i, input bit last);
        logic [191:0] pl;
        logic [2:0]   ty;
        pl = {{5{32'(base * 256 + i)}}, (i == 0) ? 32'hAF000001 : 32'(base * 256 + i)};
        ty = (i == 0) ? 3'd0 : 3'(((i - 1) % 4) + 1);
        return {pl, 5'(i + 1), ty, last, 1'(i % 2)};
    endfunction

    task automatic send_pkt(input logic [ON-1:0] o, input int n, input int base);
        exp_t          e;
        logic [DW-1:0] w;
        int            stored;
        stored = (n < TB_DEPTH) ? n : TB_DEPTH;
        for (int q = 0; q < ON; q++) begin
            if (o[q]) begin
                for (int i = 0; i < stored; i++) begin
                    w = mk(base, i, i == n - 1);
                    if (i == TB_DEPTH - 1) w[1] = 1'b1;
                    e.qid  = QW'(q);
                    e.data = w;
                    sb.push_back(e);
                end
            end
        end
        for (int i = 0; i < n; i++) begin
            din_valid = 1'b1;
            din       = mk(base, i, i == n - 1);
            oq        = (i == 0) ? o : '0;
            @(posedge memclk);
            #1;
            if (i == 0 && n > 1) check("capture_npe", 256'(next_pkg_en), 256'(0));
        end
        din_valid = 1'b0;
        din       = '0;
        oq        = '0;
        last_ncyc = ncyc;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge memclk);
            n++;
        end
        check(name, 256'(sb.size()), 256'(0));
        repeat (3) @(posedge memclk);
        #1;
    endtask

    initial begin
        int n;
        int lat;
        #1 reset = 1'b1;
        #1;
        check("rst_dout_valid", 256'(dout_valid), 256'(0));
        check("rst_queue_id", 256'(queue_id), 256'(0));
        check("rst_dout", 256'(dout), 256'(0));
        check("rst_npe", 256'(next_pkg_en), 256'(0));
        repeat (2) @(posedge memclk);
        @(negedge memclk);
        reset = 1'b0;
        #1;
        check("rel_npe_low", 256'(next_pkg_en), 256'(0));
        @(posedge memclk);
        #1;
        check("rel_npe_high", 256'(next_pkg_en), 256'(1));

        // Unicast to queue 2
        mark = out_cnt;
        send_pkt(5'b00100, 3, 1);
        wait_drain("uni_drain");
        check("uni_count", 256'(out_cnt - mark), 256'(3));
        lat = (out_cnt > mark) ? out_ncyc[mark] - last_ncyc : -1;
        check("uni_latency", 256'(lat), 256'(2));
        check("uni_npe", 256'(next_pkg_en), 256'(1));

        // Multicast to queues 0, 2, 4
        mark = out_cnt;
        send_pkt(5'b10101, 2, 2);
        wait_drain("mc_drain");
        check("mc_count", 256'(out_cnt - mark), 256'(6));
        lat = (out_cnt >= mark + 6) ? out_ncyc[mark + 5] - out_ncyc[mark] : -1;
        check("mc_no_gap", 256'(lat), 256'(5));

        // Empty bitmap: packet dropped
        mark = out_cnt;
        send_pkt(5'b00000, 4, 3);
        check("drop_npe", 256'(next_pkg_en), 256'(1));
        repeat (6) @(posedge memclk);
        #1;
        check("drop_count", 256'(out_cnt - mark), 256'(0));

        // Overflow: 10 words into an 8-word buffer
        mark = out_cnt;
        send_pkt(5'b00001, 10, 4);
        wait_drain("ovf_drain");
        check("ovf_count", 256'(out_cnt - mark), 256'(8));

        // Data word in IDLE is ignored, next header is taken
        mark = out_cnt;
        din_valid = 1'b1;
        din       = mk(5, 1, 1'b1);
        oq        = 5'b00010;
        @(posedge memclk);
        #1;
        din_valid = 1'b0;
        din       = '0;
        oq        = '0;
        check("proto_npe", 256'(next_pkg_en), 256'(1));
        repeat (4) @(posedge memclk);
        #1;
        check("proto_ignored", 256'(out_cnt - mark), 256'(0));
        send_pkt(5'b01000, 1, 6);
        wait_drain("proto_drain");
        check("proto_count", 256'(out_cnt - mark), 256'(1));

        // Reset during the second replay of a multicast
        mark = out_cnt;
        send_pkt(5'b00011, 2, 7);
        n = 0;
        while (out_cnt < mark + 3 && n < 50) begin
            @(negedge memclk);
            n++;
        end
        check("rst_reached_replay2", 256'(out_cnt >= mark + 3), 256'(1));
        #2 reset = 1'b1;
        #1;
        check("mid_rst_dout_valid", 256'(dout_valid), 256'(0));
        check("mid_rst_queue_id", 256'(queue_id), 256'(0));
        check("mid_rst_npe", 256'(next_pkg_en), 256'(0));
        sb.delete();
        @(posedge memclk);
        @(negedge memclk);
        reset = 1'b0;
        @(posedge memclk);
        #1;
        check("post_rst_npe", 256'(next_pkg_en), 256'(1));
        mark = out_cnt;
        send_pkt(5'b10000, 3, 8);
        wait_drain("post_rst_drain");
        check("post_rst_count", 256'(out_cnt - mark), 256'(3));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
